// File: rtl/if_fetch_pkg.sv
// Shared RISC-V definitions used by the fetch stage and its buffers.
package if_fetch_pkg;

  // Architectural data/address width.
  localparam int unsigned RV_XLEN = 32;

  // Low two bits of every 32-bit (non-compressed) instruction.
  localparam logic [1:0] RV_ILEN32 = 2'b11;

  // Width of a counter that must hold the values 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Small first-word-fall-through FIFO with synchronous flush and
// simultaneous push/pop (also when full). The head is visible on rdata
// in the cycle after it was pushed.
module if_fifo
  import if_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wptr_reg;
  logic [PW-1:0]    rptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count_reg != '0);
    do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_reg[wptr_reg] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) wptr_reg <= ptr_inc(wptr_reg);
      if (do_pop)  rptr_reg <= ptr_inc(rptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_reg[rptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: issues word fetches under a credit rule so the
// instruction buffer can never overflow, pairs in-order responses with
// their PCs and presents them to decode. A redirect flushes everything
// and marks in-flight responses for discard.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = RV_XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h0000_0000),
  parameter int unsigned      DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            id_illegal
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0]   pc_reg;
  logic [CW-1:0]     outstanding_reg;
  logic [CW-1:0]     discard_reg;

  logic              grant;
  logic              rsp_seen;
  logic              rsp_accept;
  logic              pop;
  logic [XLEN-1:0]   rsp_pc;
  logic [CW-1:0]     aq_count;
  logic [CW-1:0]     ib_count;
  logic [2*XLEN-1:0] ib_head;

  // Request only while out of reset, not redirecting, and with a free buffer slot reserved.
  always_comb begin
    imem_req   = rst && !redirect_valid &&
                 (((CW+1)'(outstanding_reg) + (CW+1)'(ib_count)) < (CW+1)'(DEPTH));
    imem_addr  = pc_reg & ~XLEN'(3);
    grant      = imem_req && imem_gnt;
    rsp_seen   = imem_rvalid && (outstanding_reg != '0);
    rsp_accept = imem_rvalid && (discard_reg == '0) && !redirect_valid;
    id_valid   = (ib_count != '0);
    pop        = id_valid && id_ready;
    id_pc      = id_valid ? ib_head[2*XLEN-1:XLEN] : '0;
    id_instr   = id_valid ? ib_head[XLEN-1:0] : '0;
    id_illegal = id_valid && (ib_head[1:0] != RV_ILEN32);
  end

  // Fetch PC, in-flight request count and stale-response count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= '0;
      discard_reg     <= '0;
    end else if (redirect_valid) begin
      // No grant is possible here; a response in this cycle is dropped directly.
      pc_reg          <= redirect_pc & ~XLEN'(3);
      outstanding_reg <= outstanding_reg - CW'(rsp_seen);
      discard_reg     <= outstanding_reg - CW'(rsp_seen);
    end else begin
      if (grant) pc_reg <= pc_reg + XLEN'(4);
      outstanding_reg <= outstanding_reg + CW'(grant) - CW'(rsp_seen);
      if (imem_rvalid && (discard_reg != '0)) discard_reg <= discard_reg - 1'b1;
    end
  end

  // PCs of accepted requests, waiting for their responses.
  if_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_addr_q (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (grant),
    .wdata (imem_addr),
    .pop   (rsp_accept),
    .rdata (rsp_pc),
    .count (aq_count)
  );

  // Fetched {pc, instruction} pairs waiting for decode.
  if_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (rsp_accept),
    .wdata ({rsp_pc, imem_rdata}),
    .pop   (pop),
    .rdata (ib_head),
    .count (ib_count)
  );

  // A response with nothing in flight is a memory-side protocol error.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!rst)
    imem_rvalid |-> (outstanding_reg != '0));

  // Live queued PCs never exceed requests in flight.
  a_aq_bounded: assert property (@(posedge clk) disable iff (!rst)
    aq_count <= outstanding_reg);

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// traffic, compared against a transaction-level model of the fetch stream.
module tb_if_fetch;

  localparam int unsigned     XLEN     = 32;
  localparam int unsigned     DEPTH    = 2;
  localparam logic [31:0]     RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_illegal;

  always #5 clk = ~clk;

  if_fetch #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_instr       (id_instr),
    .id_illegal     (id_illegal)
  );

  // Memory model: in-order queue of granted fetches, tagged with the
  // redirect epoch in which they were issued.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
  } mreq_t;

  mreq_t       memq[$];
  int          epoch;
  int          buf_m;        // instructions the decode stage could still receive
  logic [31:0] fetch_pc;     // next address the stage should fetch
  logic [31:0] exp_pc;       // PC of the next instruction decode should see
  int          tests = 0;
  int          fails = 0;

  logic [31:0] grants_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_instr_q[$];
  logic        pop_ill_q[$];

  logic        obs_req;
  logic        obs_valid;
  logic [31:0] obs_addr;
  logic [31:0] obs_pc;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'h0000_0013;
    if (a == 32'h0000_0204) return 32'h0000_0010;
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check outputs,
  // then advance the model to the state after the next rising edge.
  task automatic step(input bit gnt, input bit rv_en, input bit rdy,
                      input bit redir, input logic [31:0] tgt);
    bit          rv;
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] w;
    mreq_t       head;
    @(negedge clk);
    rv             = rv_en && (memq.size() > 0);
    imem_gnt       = gnt;
    id_ready       = rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    imem_rvalid    = rv;
    imem_rdata     = rv ? word_at(memq[0].addr) : $urandom;
    #1;
    exp_req   = !redir && ((memq.size() + buf_m) < DEPTH);
    exp_valid = (buf_m != 0);
    obs_req   = imem_req;
    obs_valid = id_valid;
    obs_addr  = imem_addr;
    obs_pc    = id_pc;
    chk("imem_req", imem_req, exp_req);
    chk("id_valid", id_valid, exp_valid);
    if (exp_valid) begin
      w = word_at(exp_pc);
      chk("id_pc", id_pc, exp_pc);
      chk("id_instr", id_instr, w);
      chk("id_illegal", id_illegal, w[1:0] != 2'b11);
    end
    if (imem_req) chk("imem_addr", imem_addr, fetch_pc);
    $display("[TB] t=%0t gnt=%0b rv=%0b rdy=%0b redir=%0b req=%0b addr=%h valid=%0b pc=%h",
             $time, gnt, rv, rdy, redir, imem_req, imem_addr, id_valid, id_pc);
    if (id_valid && rdy) begin
      pop_pc_q.push_back(id_pc);
      pop_instr_q.push_back(id_instr);
      pop_ill_q.push_back(id_illegal);
    end
    if (exp_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
      buf_m--;
    end
    if (rv) begin
      head = memq.pop_front();
      if (!redir && head.epoch == epoch) buf_m++;
    end
    if (imem_req && gnt) begin
      memq.push_back('{addr: imem_addr, epoch: epoch});
      grants_q.push_back(imem_addr);
      fetch_pc = fetch_pc + 32'd4;
    end
    if (redir) begin
      epoch++;
      buf_m    = 0;
      fetch_pc = tgt & ~32'd3;
      exp_pc   = tgt & ~32'd3;
    end
  endtask

  // Assert reset between clock edges and check everything clears at once;
  // the memory side is reset together with the fetch stage.
  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst            = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    id_ready       = 1'b0;
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_id_valid", id_valid, 1'b0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);
    chk("rst_id_illegal", id_illegal, 1'b0);
    memq.delete();
    grants_q.delete();
    pop_pc_q.delete();
    pop_instr_q.delete();
    pop_ill_q.delete();
    epoch    = 0;
    buf_m    = 0;
    fetch_pc = RESET_PC;
    exp_pc   = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // Reset and back-to-back fetch with single-cycle responses.
    apply_reset();
    step(1, 1, 1, 0, 0);
    chk("a_first_req", obs_req, 1'b1);
    chk("a_first_addr", obs_addr, RESET_PC);
    chk("a_valid_c0", obs_valid, 1'b0);
    step(1, 1, 1, 0, 0);
    chk("a_valid_c1", obs_valid, 1'b0);
    step(1, 1, 1, 0, 0);
    chk("a_valid_c2", obs_valid, 1'b1);
    chk("a_pc_c2", obs_pc, 32'h0);
    repeat (3) step(1, 1, 1, 0, 0);
    chk("a_ngrants", grants_q.size() >= 3, 1'b1);
    if (grants_q.size() >= 3) begin
      chk("a_addr0", grants_q[0], 32'h0);
      chk("a_addr1", grants_q[1], 32'h4);
      chk("a_addr2", grants_q[2], 32'h8);
    end

    // Decode stalled: credit rule stops fetch after DEPTH grants.
    apply_reset();
    repeat (6) step(1, 1, 0, 0, 0);
    chk("b_grants", grants_q.size(), 2);
    chk("b_req_low", obs_req, 1'b0);
    chk("b_pc_hold", obs_pc, 32'h0);
    repeat (2) step(1, 1, 1, 0, 0);
    chk("b_pops", pop_pc_q.size(), 2);
    chk("b_resume", grants_q.size() > 2, 1'b1);

    // Redirect with two requests in flight.
    apply_reset();
    repeat (2) step(1, 0, 1, 0, 0);
    step(1, 0, 1, 1, 32'h0000_0103);
    chk("c_req_redir", obs_req, 1'b0);
    step(1, 1, 1, 0, 0);
    chk("c_addr", obs_addr, 32'h0000_0100);
    repeat (8) step(1, 1, 1, 0, 0);
    chk("c_npops", pop_pc_q.size() > 0, 1'b1);
    if (pop_pc_q.size() > 0) chk("c_first_pc", pop_pc_q[0], 32'h0000_0100);
    if (grants_q.size() > 2) chk("c_grant2", grants_q[2], 32'h0000_0100);

    // Redirect coinciding with a response.
    apply_reset();
    repeat (2) step(1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 32'h0000_0040);
    @(posedge clk);
    #1;
    chk("d_discard", dut.discard_reg, 1);
    chk("d_outstanding", dut.outstanding_reg, 1);
    repeat (8) step(1, 1, 1, 0, 0);
    chk("d_npops", pop_pc_q.size() > 0, 1'b1);
    if (pop_pc_q.size() > 0) chk("d_first_pc", pop_pc_q[0], 32'h0000_0040);

    // Instruction-length check.
    apply_reset();
    step(1, 0, 1, 1, 32'h0000_0200);
    repeat (8) step(1, 1, 1, 0, 0);
    chk("e_npops", pop_pc_q.size() >= 2, 1'b1);
    if (pop_pc_q.size() >= 2) begin
      chk("e_pc0", pop_pc_q[0], 32'h0000_0200);
      chk("e_instr0", pop_instr_q[0], 32'h0000_0013);
      chk("e_ill0", pop_ill_q[0], 1'b0);
      chk("e_pc1", pop_pc_q[1], 32'h0000_0204);
      chk("e_instr1", pop_instr_q[1], 32'h0000_0010);
      chk("e_ill1", pop_ill_q[1], 1'b1);
    end

    // Reset mid-burst with requests outstanding.
    apply_reset();
    step(1, 1, 1, 0, 0);
    step(1, 0, 1, 0, 0);
    apply_reset();
    step(1, 1, 1, 0, 0);
    chk("f_req", obs_req, 1'b1);
    chk("f_addr", obs_addr, RESET_PC);

    // Random traffic, including wrap-around targets and stalls.
    apply_reset();
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) apply_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
           (i % 7 == 0) ? 32'hFFFF_FFF8 : $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
